power_avg: RTL
==============

# power_avg

Average-power estimator at the front of the receiver detection chain. It consumes complex baseband samples, forms |x|² = I² + Q² per sample, and averages over a fixed window of 2^LOG2_N accepted samples. Once per window it emits a 32-bit unsigned power word with a one-cycle valid pulse, which feeds directly into the power-to-dB converter.

## Interface
Parameters:
- DW, 16: width of signed I and Q inputs; legal range 2..16.
- LOG2_N, 10: log2 of the window length N; legal range 1..16.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous window restart.
- valid_i  in  1  sample qualifier; no backpressure.
- i_i  in  DW  signed in-phase sample.
- q_i  in  DW  signed quadrature sample.
- power_o  out  32  unsigned mean of I²+Q² over the last completed window.
- valid_o  out  1  one-cycle pulse when power_o updates.
- clip_o  out  1  exists only with POWER_AVG_CLIP_EN.

## Operation
- Stage 0 (capture edge): when valid_i=1, register sq_i=i_i*i_i and sq_q=q_i*q_i as unsigned 2·DW-bit values, plus a stage valid bit.
- Stage 1: register sum = sq_i + sq_q as unsigned 32-bit, plus a valid bit.
  - Maximum sum is 2·(2^(DW-1))² = 2^(2DW-1) ≤ 2^31, so it fits with no overflow.
- Stage 2 (accumulate): when the stage-1 valid bit is set:
  - acc (32+LOG2_N bits) += sum; cnt (LOG2_N bits) increments.
  - On the sample where cnt == N-1:
    - power_o <= (acc + sum) >> LOG2_N, truncated (floor).
    - valid_o <= 1.
    - acc <= 0 and cnt <= 0. The counter wraps back to 0.
- The result never exceeds 2^31, so no saturation logic is needed.
- Windows are back-to-back and non-overlapping. The sample after a window-closing sample is the first sample of the next window.
- Gaps in valid_i only stretch the window in time. Every stage holds its state while no valid sample is present.
- power_o holds its value between updates.
- clear_i=1:
  - At the next edge, zero all pipeline valid bits, acc and cnt. In-flight samples are discarded and no valid_o is generated from them.
  - power_o is not changed.
  - If clear_i and valid_i are both 1, clear wins and the sample is dropped.
  - If clear_i coincides with a window-closing stage-2 sample, clear wins and no valid_o is issued.
- Reset (rst_n=0): asynchronously zeroes every register, including a reset asserted mid-window. The window restarts from the first valid sample after release.

## Timing
- Reset values: power_o=0, valid_o=0, clip_o=0.
- Latency: the Nth sample of a window is captured at edge k; power_o and valid_o update at edge k+3. valid_o is high for exactly one cycle.
- Throughput: one sample per clock, sustained indefinitely.
- Minimum spacing between valid_o pulses is N cycles.

## Configuration
- POWER_AVG_CLIP_EN defined:
  - clip_o is present.
  - A sticky per-window flag sets when any accepted I or Q equals -2^(DW-1) or 2^(DW-1)-1.
  - The flag is evaluated at stage 0 and carried down the pipeline aligned with the sample.
  - clip_o is updated together with power_o and valid_o, and holds between updates.
  - The sticky flag clears at window close, on clear_i, and on reset.
- POWER_AVG_CLIP_EN undefined: the clip_o port and all its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use DW=16 and LOG2_N=2 (N=4).
- Continuous I=3, Q=4 for 8 cycles -> two valid_o pulses, 4 cycles apart, both with power_o=25. First pulse at edge 3 after the 4th sample.
- Four samples with I=Q=-32768 -> power_o=0x80000000. With POWER_AVG_CLIP_EN, clip_o=1.
- Samples (1,0), (0,2), (3,0), (0,1), i.e. sums 1, 4, 9, 1 -> power_o=3 (floor of 15/4). With POWER_AVG_CLIP_EN, clip_o=0.
- The same four samples with 1-5 idle cycles between them -> power_o=3, valid_o 3 edges after the last sample, no other pulses.
- 2 samples of (100,0), then clear_i together with a 3rd sample, then 4 samples of (2,0) -> exactly one valid_o, with power_o=4.
- rst_n pulsed low after 3 samples of (10,0) -> outputs are 0 immediately. The next 4 samples of (1,1) give power_o=2, with no pulse before them.

Source files
------------

// File: rtl/power_avg.sv
// Windowed mean of I^2+Q^2 over 2^LOG2_N accepted samples; one result word per window.
// Latency 3 edges from capture of the window's last sample; no backpressure. Optional clip flag: POWER_AVG_CLIP_EN.
module power_avg #(
  parameter int DW     = 16,
  parameter int LOG2_N = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] i_i,
  input  logic [DW-1:0] q_i,
  output logic [31:0]   power_o,
  output logic          valid_o
`ifdef POWER_AVG_CLIP_EN
  ,
  output logic          clip_o
`endif
);

  localparam int AW = 32 + LOG2_N;

  // stage 0: squares
  logic signed [2*DW-1:0] prod_i, prod_q;
  logic [2*DW-1:0]        sq_i, sq_q;
  logic                   v0;

  // stage 1: sum of squares
  logic [31:0]            sum;
  logic                   v1;

  // stage 2: accumulator and window result
  logic [AW-1:0]          acc, acc_next;
  logic [LOG2_N-1:0]      cnt;
  logic                   last;
  logic [31:0]            res;
  logic                   res_v;

  assign prod_i   = $signed(i_i) * $signed(i_i);
  assign prod_q   = $signed(q_i) * $signed(q_i);
  assign acc_next = acc + AW'(sum);
  assign last     = (cnt == {LOG2_N{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_i    <= '0;
      sq_q    <= '0;
      v0      <= 1'b0;
      sum     <= '0;
      v1      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
      res_v   <= 1'b0;
      power_o <= '0;
      valid_o <= 1'b0;
    end else if (clear_i) begin
      // data registers keep their contents; only the valid chain and window state restart
      v0      <= 1'b0;
      v1      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      res_v   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      v0 <= valid_i;
      if (valid_i) begin
        sq_i <= prod_i;
        sq_q <= prod_q;
      end

      v1 <= v0;
      if (v0) sum <= 32'(sq_i) + 32'(sq_q);

      res_v <= v1 && last;
      if (v1) begin
        if (last) begin
          res <= 32'(acc_next >> LOG2_N);
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end

      valid_o <= res_v;
      if (res_v) power_o <= res;
    end
  end

`ifdef POWER_AVG_CLIP_EN
  logic [DW-1:0] code_min, code_max;
  logic          c0, c1, clip_acc, res_clip;

  assign code_min = {1'b1, {(DW-1){1'b0}}};
  assign code_max = {1'b0, {(DW-1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0       <= 1'b0;
      c1       <= 1'b0;
      clip_acc <= 1'b0;
      res_clip <= 1'b0;
      clip_o   <= 1'b0;
    end else if (clear_i) begin
      clip_acc <= 1'b0;
    end else begin
      if (valid_i)
        c0 <= (i_i == code_min) || (i_i == code_max) ||
              (q_i == code_min) || (q_i == code_max);
      if (v0) c1 <= c0;
      if (v1) begin
        if (last) begin
          res_clip <= clip_acc | c1;
          clip_acc <= 1'b0;
        end else begin
          clip_acc <= clip_acc | c1;
        end
      end
      if (res_v) clip_o <= res_clip;
    end
  end
`endif

endmodule
